// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
package i2c_pkg;

  localparam logic I2C_ACK    = 1'b0;
  localparam logic I2C_NACK   = 1'b1;
  localparam int   I2C_ADDR_W = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_RX,
    S_RX_ACK,
    S_TX,
    S_TX_ACK,
    S_IGNORE
  } i2c_slv_state_t;

endpackage

// File: rtl/i2c_slave_if.sv
// User-side byte interface of the I2C target: RX bytes out, TX bytes in.
interface i2c_slave_if;
  logic [7:0] i_tx_data;
  logic       o_tx_load;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       o_rw;
  logic       o_busy;

  // the I2C target itself
  modport slave (
    input  i_tx_data,
    output o_tx_load, o_rx_data, o_rx_valid, o_rw, o_busy
  );

  // user logic (register bank / FIFO) attached to the target
  modport master (
    output i_tx_data,
    input  o_tx_load, o_rx_data, o_rx_valid, o_rw, o_busy
  );
endinterface

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer followed by one edge-detect flop.
// Level and edge pulses appear SYNC_STAGES+1 cycles after the pin changes.
module i2c_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b1   // idle bus level, avoids fake edges out of reset
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic                   rise_q;
  logic                   fall_q;

  // synchronizer chain plus registered edge detection
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      dly_q  <= sync_q[SYNC_STAGES-1];
      rise_q <=  sync_q[SYNC_STAGES-1] & ~dly_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] &  dly_q;
    end
  end

  assign lvl_o  = dly_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target, 7-bit addressing, no clock stretching. SCL/SDA are oversampled
// in the system clock domain; SDA is only ever pulled low or released.
module i2c_slave import i2c_pkg::*; #(
  parameter logic [I2C_ADDR_W-1:0] ADDR        = 7'h42,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_scl,
  inout  wire            io_sda,
  i2c_slave_if.slave     usr
);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_scl (
    .clk_i  (i_clk),
    .rst_n_i(i_rst_n),
    .d_i    (i_scl),
    .lvl_o  (scl_s),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sda (
    .clk_i  (i_clk),
    .rst_n_i(i_rst_n),
    .d_i    (io_sda),
    .lvl_o  (sda_s),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  i2c_slv_state_t state_q;
  logic [6:0]     sh_q;        // first 7 bits; the 8th comes straight from the line
  logic [7:0]     byte_d;
  logic [7:0]     tx_q;
  logic [2:0]     cnt_q;
  logic           sda_oe_q;
  logic           rw_q;
  logic           busy_q;
  logic [7:0]     rx_data_q;
  logic           rx_valid_q;
  logic           tx_load_q;
  logic           ack_seen_q;  // master ACK sampled in TX_ACK, reload on next fall

  // Our own pull-down shows up on the synchronized SDA a few cycles late, so
  // START/STOP are masked while we drive and until the pipeline has drained.
  logic [SYNC_STAGES+1:0] oe_hist_q;
  logic                   own_drv;
  logic                   start_ev;
  logic                   stop_ev;

  assign own_drv  = sda_oe_q | (|oe_hist_q);
  assign start_ev = sda_fall & scl_s & ~own_drv;
  assign stop_ev  = sda_rise & scl_s & ~own_drv;
  assign byte_d   = {sh_q, sda_s};

  // history of the SDA drive enable, covers the synchronizer latency
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) oe_hist_q <= '0;
    else          oe_hist_q <= {oe_hist_q[SYNC_STAGES:0], sda_oe_q};
  end

  // protocol FSM with registered outputs and SDA drive enable
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      sh_q       <= '0;
      tx_q       <= '0;
      cnt_q      <= '0;
      sda_oe_q   <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      ack_seen_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      if (stop_ev) begin
        state_q  <= S_IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
        cnt_q    <= '0;
      end else if (start_ev) begin
        state_q  <= S_ADDR;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
        cnt_q    <= '0;
      end else begin
        case (state_q)
          S_ADDR: if (scl_rise) begin
            sh_q  <= byte_d[6:0];
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              // general call (address 0) is never claimed
              if (byte_d[7:1] == ADDR && ADDR != '0) begin
                rw_q    <= byte_d[0];
                busy_q  <= 1'b1;
                state_q <= S_ADDR_ACK;
              end else begin
                state_q <= S_IGNORE;
              end
            end
          end
          S_ADDR_ACK: if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_q <= ~I2C_ACK;
            end else if (rw_q) begin
              // end of ACK: fetch first read byte and put its MSB on the line
              tx_load_q <= 1'b1;
              tx_q      <= {usr.i_tx_data[6:0], 1'b0};
              sda_oe_q  <= ~usr.i_tx_data[7];
              state_q   <= S_TX;
            end else begin
              sda_oe_q <= 1'b0;
              state_q  <= S_RX;
            end
          end
          S_RX: if (scl_rise) begin
            sh_q  <= byte_d[6:0];
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rx_data_q  <= byte_d;
              rx_valid_q <= 1'b1;
              state_q    <= S_RX_ACK;
            end
          end
          S_RX_ACK: if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_q <= ~I2C_ACK;
            end else begin
              sda_oe_q <= 1'b0;
              state_q  <= S_RX;
            end
          end
          S_TX: begin
            // count rises; a fall after the 8th rise (counter wrapped) ends the byte
            if (scl_rise) begin
              cnt_q <= cnt_q + 3'd1;
            end else if (scl_fall) begin
              if (cnt_q == 3'd0) begin
                sda_oe_q   <= 1'b0;
                ack_seen_q <= 1'b0;
                state_q    <= S_TX_ACK;
              end else begin
                sda_oe_q <= ~tx_q[7];
                tx_q     <= {tx_q[6:0], 1'b0};
              end
            end
          end
          S_TX_ACK: begin
            if (scl_rise) begin
              if (sda_s == I2C_NACK) begin
                busy_q  <= 1'b0;
                state_q <= S_IGNORE;
              end else begin
                ack_seen_q <= 1'b1;
              end
            end else if (scl_fall && ack_seen_q) begin
              ack_seen_q <= 1'b0;
              tx_load_q  <= 1'b1;
              tx_q       <= {usr.i_tx_data[6:0], 1'b0};
              sda_oe_q   <= ~usr.i_tx_data[7];
              state_q    <= S_TX;
            end
          end
          default: sda_oe_q <= 1'b0;  // IDLE / IGNORE: bus released
        endcase
      end
    end
  end

  assign io_sda         = sda_oe_q ? 1'b0 : 1'bz;
  assign usr.o_tx_load  = tx_load_q;
  assign usr.o_rx_data  = rx_data_q;
  assign usr.o_rx_valid = rx_valid_q;
  assign usr.o_rw       = rw_q;
  assign usr.o_busy     = busy_q;

endmodule
